// File: rtl/conv_stream_ctrl.sv
// conv_stream_ctrl: AXI-Stream front/back end for a stall-gated convolution pipeline.
// Accepted input beats drive the pipeline. A tag shift register marks which pipeline
// slots hold real pixels, so results leave on m_axis with SOF (tuser) and EOF (tlast)
// marks. After a frame, zero beats flush the pipe, and a one-cycle reset then clears it.
//
// Build option: SOF_RESYNC_EN
//    defined   - in IDLE only a beat with s_axis_tuser=1 starts a frame; other beats are
//                accepted and dropped.
//    undefined - any accepted beat in IDLE starts a frame; s_axis_tuser is ignored.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for the first beat of a frame
// RUN    | forwarding frame beats into the pipe, in_cnt = index of next beat
// FLUSH  | injecting zero beats until the last real result has left
// PRST   | one cycle of pipeline reset, then back to IDLE

module conv_stream_ctrl #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int DATA_WIDTH      = 8*PIXELS_PER_BEAT,
    parameter int PIPE_LATENCY    = 40
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    output logic                  pipe_stall,
    output logic                  pipe_rst_n,
    output logic [DATA_WIDTH-1:0] pipe_in_frame,
    input  logic [DATA_WIDTH-1:0] pipe_out_frame,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  err_tlast
);

    localparam int FRAME_BEATS = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT;
    localparam int CNT_W       = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam int FL_W        = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(FRAME_BEATS-1);
    localparam logic [FL_W-1:0]  LAST_FLUSH = FL_W'(PIPE_LATENCY-1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_PRST} state_t;

    state_t                  state, state_nxt;
    logic [PIPE_LATENCY-1:0] tag;
    logic [CNT_W-1:0]        in_cnt, in_cnt_nxt, out_cnt;
    logic [FL_W-1:0]         flush_cnt, flush_cnt_nxt;
    logic                    tag_last, out_ok, adv, tag_in, in_sel, out_en;
    logic                    s_ready, err_set, at_last, sof_ok, m_hs;

`ifdef SOF_RESYNC_EN
    assign sof_ok = s_axis_tuser;
`else
    logic unused_tuser;
    assign sof_ok       = 1'b1;
    assign unused_tuser = s_axis_tuser;
`endif

    assign tag_last = tag[PIPE_LATENCY-1];
    assign out_ok   = ~tag_last | m_axis_tready;
    // In IDLE in_cnt is always 0, so the same compare serves the first beat too.
    assign at_last  = (in_cnt == LAST_BEAT);

    // Next state, pipe advance and input acceptance.
    always_comb begin
        state_nxt     = state;
        in_cnt_nxt    = in_cnt;
        flush_cnt_nxt = flush_cnt;
        s_ready       = 1'b0;
        adv           = 1'b0;
        tag_in        = 1'b0;
        in_sel        = 1'b0;
        out_en        = 1'b0;
        err_set       = 1'b0;
        if (aresetn) begin
            case (state)
                S_IDLE, S_RUN: begin
                    s_ready = out_ok;
                    in_sel  = 1'b1;
                    // Output may only be offered when the pipe can move with it;
                    // otherwise a consumed result would be presented again.
                    out_en  = s_axis_tvalid;
                    if (s_axis_tvalid && out_ok && (sof_ok || state == S_RUN)) begin
                        adv     = 1'b1;
                        tag_in  = 1'b1;
                        err_set = s_axis_tlast ^ at_last;
                        if (at_last) begin
                            state_nxt     = S_FLUSH;
                            in_cnt_nxt    = '0;
                            flush_cnt_nxt = '0;
                        end else begin
                            state_nxt  = S_RUN;
                            in_cnt_nxt = in_cnt + CNT_W'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    out_en = 1'b1;
                    adv    = out_ok;
                    if (out_ok) begin
                        flush_cnt_nxt = flush_cnt + FL_W'(1);
                        if (flush_cnt == LAST_FLUSH) state_nxt = S_PRST;
                    end
                end
                S_PRST:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign s_axis_tready = s_ready;
    assign pipe_stall    = ~adv;
    assign pipe_rst_n    = aresetn & (state != S_PRST);
    assign pipe_in_frame = in_sel ? s_axis_tdata : '0;
    assign m_axis_tdata  = pipe_out_frame;
    assign m_axis_tvalid = tag_last & out_en;
    assign m_axis_tuser  = m_axis_tvalid & (out_cnt == '0);
    assign m_axis_tlast  = m_axis_tvalid & (out_cnt == LAST_BEAT);
    assign m_hs          = m_axis_tvalid & m_axis_tready;

    // State, counters, tag shift register and sticky tlast error.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state     <= S_IDLE;
            tag       <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            flush_cnt <= '0;
            err_tlast <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_cnt    <= in_cnt_nxt;
            flush_cnt <= flush_cnt_nxt;
            if (adv) tag <= PIPE_LATENCY'({tag, tag_in});
            if (m_hs) out_cnt <= (out_cnt == LAST_BEAT) ? '0 : out_cnt + CNT_W'(1);
            if (err_set) err_tlast <= 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Bench for conv_stream_ctrl: 32x32 frames of 16-pixel beats (64 beats), latency 5,
// stub pipe is a delay line. A transaction-level model predicts the output stream.
module tb_conv_stream_ctrl;

    localparam int PPB = 16;
    localparam int DIM = 32;
    localparam int DW  = 8*PPB;
    localparam int LAT = 5;
    localparam int FB  = DIM*DIM/PPB;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tuser = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic          pipe_stall, pipe_rst_n;
    logic [DW-1:0] pipe_in_frame, pipe_out_frame, m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tuser, m_axis_tlast, err_tlast;
    logic          m_axis_tready = 1'b0;

    always #5 clk = ~clk;

    conv_stream_ctrl #(.PIXELS_PER_BEAT(PPB), .IMAGE_DIM(DIM), .DATA_WIDTH(DW), .PIPE_LATENCY(LAT)) dut (
        .clk(clk), .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
        .pipe_stall(pipe_stall), .pipe_rst_n(pipe_rst_n),
        .pipe_in_frame(pipe_in_frame), .pipe_out_frame(pipe_out_frame),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast), .err_tlast(err_tlast));

    // Stub pipeline: delay line that moves only when not stalled.
    logic [DW-1:0] stub [LAT];
    always @(posedge clk) begin
        if (!pipe_rst_n) begin
            for (int i = 0; i < LAT; i++) stub[i] <= '0;
        end else if (!pipe_stall) begin
            stub[0] <= pipe_in_frame;
            for (int i = 1; i < LAT; i++) stub[i] <= stub[i-1];
        end
    end
    assign pipe_out_frame = stub[LAT-1];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {logic [DW-1:0] d; logic u; logic l;} beat_t;
    beat_t src_q[$];
    int    s_valid_pct = 100;
    int    m_mode = 0;
    bit    s_fire = 0, m_fire = 0;
    int    cyc = 0;

    always @(posedge clk) cyc++;

    // Source and sink drivers.
    always @(posedge clk) begin
        #1;
        if (s_fire && src_q.size() > 0) void'(src_q.pop_front());
        if (src_q.size() == 0) begin
            s_axis_tvalid = 1'b0;
        end else begin
            if (!(s_axis_tvalid && !s_fire)) s_axis_tvalid = ($urandom_range(99) < s_valid_pct);
            s_axis_tdata = src_q[0].d;
            s_axis_tuser = src_q[0].u;
            s_axis_tlast = src_q[0].l;
        end
        case (m_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = 1'($urandom_range(1));
        endcase
    end

    // Behavioural model: frames are FB accepted beats, outputs replay them in order,
    // then input stays closed until the last result is taken plus one reset cycle.
    typedef enum int {P_IDLE, P_IN, P_DRAIN, P_PRST} phase_t;
    phase_t        ph = P_IDLE;
    int            in_idx = 0, out_idx = 0, n_out = 0;
    bit            err_m = 0;
    logic [DW-1:0] exp_q[$];
    bit            hold_prev = 0;
    logic [DW-1:0] hold_data = '0;
    bit            got_first = 0, got_acc = 0, got_valid = 0, got_prst = 0;
    logic [DW-1:0] first_out_data = '0;
    int            first_acc_cyc = 0, first_valid_cyc = 0, last_out_cyc = 0, prst_cyc = 0;

    always @(negedge clk) begin
        bit start;
        phase_t ph_old;
        s_fire = s_axis_tvalid && s_axis_tready;
        m_fire = m_axis_tvalid && m_axis_tready;
        if (!aresetn) begin
            chk("rst_tready", s_axis_tready, 0);
            chk("rst_stall", pipe_stall, 1);
            chk("rst_pipe_rst_n", pipe_rst_n, 0);
            chk("rst_mvalid", m_axis_tvalid, 0);
            ph = P_IDLE; in_idx = 0; out_idx = 0; err_m = 0;
            exp_q.delete(); hold_prev = 0;
        end else begin
`ifdef SOF_RESYNC_EN
            start = s_fire && s_axis_tuser;
`else
            start = s_fire;
`endif
            chk("err_tlast", err_tlast, err_m);
            chk("pipe_rst_n", pipe_rst_n, ph != P_PRST);
            case (ph)
                P_IDLE: begin
                    chk("idle_tready", s_axis_tready, 1);
                    chk("idle_mvalid", m_axis_tvalid, 0);
                    chk("idle_adv", !pipe_stall, start);
                    if (start) chk("idle_pipe_in", pipe_in_frame, s_axis_tdata);
                end
                P_IN: begin
                    if (m_axis_tready) chk("run_tready", s_axis_tready, 1);
                    chk("run_adv", !pipe_stall, s_fire);
                    if (s_fire) chk("run_pipe_in", pipe_in_frame, s_axis_tdata);
                end
                P_DRAIN: begin
                    chk("flush_tready", s_axis_tready, 0);
                    chk("flush_stall", pipe_stall, m_axis_tvalid && !m_axis_tready);
                    if (!pipe_stall) chk("flush_pipe_in", pipe_in_frame, 0);
                end
                default: begin
                    chk("prst_tready", s_axis_tready, 0);
                    chk("prst_stall", pipe_stall, 1);
                    chk("prst_mvalid", m_axis_tvalid, 0);
                end
            endcase
            if (m_axis_tvalid) begin
                chk("out_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    chk("out_data", m_axis_tdata, exp_q[0]);
                    chk("out_tuser", m_axis_tuser, out_idx == 0);
                    chk("out_tlast", m_axis_tlast, out_idx == FB-1);
                end
                if (hold_prev) chk("out_hold", m_axis_tdata, hold_data);
                hold_prev = !m_axis_tready;
                hold_data = m_axis_tdata;
                if (!got_valid) begin got_valid = 1; first_valid_cyc = cyc; end
            end else begin
                chk("out_marks_idle", {m_axis_tuser, m_axis_tlast}, 0);
            end
            if (!pipe_rst_n && !got_prst) begin got_prst = 1; prst_cyc = cyc; end

            ph_old = ph;
            if (m_fire && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                if (!got_first) begin got_first = 1; first_out_data = m_axis_tdata; end
                if (out_idx == FB-1) last_out_cyc = cyc;
                out_idx = (out_idx + 1) % FB;
                n_out++;
                if (ph_old == P_DRAIN && exp_q.size() == 0) ph = P_PRST;
            end
            if ((ph_old == P_IDLE && start) || (ph_old == P_IN && s_fire)) begin
                if (ph_old == P_IDLE && !got_acc) begin got_acc = 1; first_acc_cyc = cyc; end
                if (s_axis_tlast != (in_idx == FB-1)) err_m = 1;
                exp_q.push_back(s_axis_tdata);
                in_idx++;
                if (in_idx == FB) begin in_idx = 0; ph = P_DRAIN; end
                else ph = P_IN;
            end
            if (ph_old == P_PRST) ph = P_IDLE;
        end
    end

    task automatic push_frame(input int base, input int last_pos);
        for (int k = 0; k < FB; k++) begin
            beat_t b;
            b.d = DW'(base + k);
            b.u = (k == 0);
            b.l = (k == last_pos);
            src_q.push_back(b);
        end
    endtask

    task automatic arm();
        got_first = 0; got_acc = 0; got_valid = 0; got_prst = 0; n_out = 0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (src_q.size() == 0 && ph == P_IDLE && exp_q.size() == 0) begin ok = 1; break; end
        end
        chk(nm, ok, 1);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #2;
        aresetn = 1'b0;
        src_q.delete();
        repeat (n) @(posedge clk);
        #2 aresetn = 1'b1;
    endtask

    initial begin
        bit ok;
        repeat (3) @(posedge clk);
        #2 aresetn = 1'b1;

        // Full-rate frame, data = beat index.
        @(posedge clk); #2;
        arm(); push_frame(0, FB-1);
        wait_idle("A_done", 1000);
        chk("A_first_valid_latency", first_valid_cyc - first_acc_cyc, LAT);
        chk("A_last_out_cycle", last_out_cyc - first_acc_cyc, LAT + FB - 1);
        chk("A_prst_cycle", prst_cyc - first_acc_cyc, LAT + FB);
        chk("A_outputs", n_out, FB);
        chk("A_first_data", first_out_data, 0);
        chk("A_err", err_tlast, 0);

        // Sink ready toggling every cycle.
        m_mode = 1; arm(); push_frame(1000, FB-1);
        wait_idle("B_done", 2000);
        chk("B_outputs", n_out, FB);
        chk("B_first_data", first_out_data, 1000);

        // Random source valid and random sink ready.
        s_valid_pct = 50; m_mode = 2; arm(); push_frame(2000, FB-1);
        wait_idle("C_done", 4000);
        chk("C_outputs", n_out, FB);
        chk("C_first_data", first_out_data, 2000);

        // Early tlast: error is sticky, frame length unchanged, reset clears it.
        s_valid_pct = 100; m_mode = 0; arm(); push_frame(3000, 10);
        wait_idle("D_done", 1000);
        chk("D_err_set", err_tlast, 1);
        chk("D_outputs", n_out, FB);
        do_reset(2);
        chk("D_err_cleared", err_tlast, 0);

        // Reset pulse in the middle of a frame.
        s_valid_pct = 70; m_mode = 2; push_frame(4000, FB-1);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #2;
            if (in_idx >= 30) begin ok = 1; break; end
        end
        chk("E_reached_beat30", ok, 1);
        do_reset(1);
        #1;
        chk("E_post_rst_mvalid", m_axis_tvalid, 0);
        chk("E_post_rst_tuser", m_axis_tuser, 0);
        chk("E_post_rst_tlast", m_axis_tlast, 0);
        chk("E_post_rst_tdata", m_axis_tdata, 0);
        chk("E_post_rst_err", err_tlast, 0);
        arm(); push_frame(5000, FB-1);
        wait_idle("E_done", 4000);
        chk("E_outputs", n_out, FB);
        chk("E_first_data", first_out_data, 5000);

        // Three junk beats without SOF, then a real frame.
        s_valid_pct = 100; m_mode = 0; arm();
        for (int i = 0; i < 3; i++) begin
            beat_t b;
            b.d = DW'(32'hBAD0 + i); b.u = 1'b0; b.l = 1'b0;
            src_q.push_back(b);
        end
        push_frame(6000, FB-1);
`ifdef SOF_RESYNC_EN
        wait_idle("F_done", 1000);
        chk("F_first_data", first_out_data, 6000);
        chk("F_outputs", n_out, FB);
        chk("F_err", err_tlast, 0);
`else
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #2;
            if (src_q.size() == 0 && n_out >= FB) begin ok = 1; break; end
        end
        chk("F_done", ok, 1);
        chk("F_first_data", first_out_data, 32'hBAD0);
        chk("F_outputs", n_out, FB);
        do_reset(1);
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
